gate_truth_table_checker: RTL and testbench

- Sequential stimulus and response stage wrapped around a 2-input combinational gate under test (default target: the NOR cell).
- On `start`, drives the gate's A/B inputs through all four combinations and waits a programmable settle time per vector.
- Samples the gate's Y output into a 4-bit truth table and compares it against an expected table.
- Reports `done`, `pass` and a per-vector mismatch mask; used as on-chip self-test upstream and downstream of the gate.

---
 rtl/gate_chk_pkg.sv | 17 +
 rtl/gate_truth_table_checker.sv | 118 +++++++++++
 tb/tb_gate_truth_table_checker.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_chk_pkg.sv
// Shared types and golden truth tables for the gate truth-table checker.
// Table bit index is {A,B}, so bit 0 is the A=0,B=0 response.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam logic [3:0] EXP_NOR  = 4'b0001;
    localparam logic [3:0] EXP_OR   = 4'b1110;
    localparam logic [3:0] EXP_AND  = 4'b1000;
    localparam logic [3:0] EXP_NAND = 4'b0111;
    localparam logic [3:0] EXP_XOR  = 4'b0110;

endpackage

// File: rtl/gate_truth_table_checker.sv
// Sweeps {A,B} through 00..11 with SETTLE_CYCLES per vector, captures Y into a truth table and grades it.
// done pulses 4*SETTLE_CYCLES+1 edges after start is accepted; start is ignored while busy.
module gate_truth_table_checker
    import gate_chk_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] EXPECTED      = EXP_NOR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       A,
    output logic       B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic [3:0] table_out,
    output logic [3:0] mismatch,
    output logic       pass
);

    localparam int             CW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE_CYCLES - 1);

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ab_q, ab_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [3:0]    table_q, table_d;
    logic [3:0]    mis_q, mis_d;
    logic          pass_q, pass_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            ab_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            mis_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ab_q    <= ab_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            table_q <= table_d;
            mis_q   <= mis_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ab_d    = ab_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        table_d = table_q;
        mis_d   = mis_q;
        pass_d  = pass_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    cnt_d   = '0;
                    ab_d    = '0;
                    busy_d  = 1'b1;
                    table_d = '0;
                    mis_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    table_d[idx_q] = Y;
                    cnt_d          = '0;
                    // idx 3 wraps to 0, which also returns A/B to 00 on the way to FIN
                    idx_d          = idx_q + 2'd1;
                    ab_d           = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = FIN;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIN: begin
                mis_d   = table_q ^ EXPECTED;
                pass_d  = (table_q == EXPECTED);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign A         = ab_q[1];
    assign B         = ab_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign mismatch  = mis_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: two instances (settle 2 and settle 1) driving bench-side gate models,
// checked every cycle against a timeline model plus directed literal scenarios.
module tb_gate_truth_table_checker;
    import gate_chk_pkg::*;

    localparam int S0 = 2;
    localparam int S1 = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] start;
    logic [1:0] y;
    logic [1:0] rnd_y;
    logic [1:0] a_w, b_w, busy_w, done_w, pass_w;
    logic [3:0] tbl_w [2];
    logic [3:0] mis_w [2];
    int         gsel  [2];
    int         sval  [2] = '{S0, S1};

    int errors = 0;
    int checks = 0;

    // Bench-side gate under test: 0 NOR, 1 OR, 2 AND, 3 NAND, 4 XOR, 5 tied 0, other random
    function automatic logic gate_y(input int g, input logic a, input logic b, input logic r);
        case (g)
            0:       return ~(a | b);
            1:       return a | b;
            2:       return a & b;
            3:       return ~(a & b);
            4:       return a ^ b;
            5:       return 1'b0;
            default: return r;
        endcase
    endfunction

    assign y[0] = gate_y(gsel[0], a_w[0], b_w[0], rnd_y[0]);
    assign y[1] = gate_y(gsel[1], a_w[1], b_w[1], rnd_y[1]);

    gate_truth_table_checker #(.SETTLE_CYCLES(S0), .EXPECTED(EXP_NOR)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .A(a_w[0]), .B(b_w[0]), .Y(y[0]),
        .busy(busy_w[0]), .done(done_w[0]), .table_out(tbl_w[0]), .mismatch(mis_w[0]), .pass(pass_w[0])
    );

    gate_truth_table_checker #(.SETTLE_CYCLES(S1), .EXPECTED(EXP_NOR)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .A(a_w[1]), .B(b_w[1]), .Y(y[1]),
        .busy(busy_w[1]), .done(done_w[1]), .table_out(tbl_w[1]), .mismatch(mis_w[1]), .pass(pass_w[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Model: a run is a timeline t = edges since the accepting edge; vector k is applied for
    // t in [k*S, (k+1)*S) and sampled at t = (k+1)*S; results land at t = 4*S+1.
    bit         m_act  [2];
    int         m_t    [2];
    logic [3:0] m_tbl  [2];
    logic [3:0] m_mis  [2];
    bit         m_pass [2];
    bit         m_done [2];
    logic [1:0] y_s, st_s;

    task automatic model_reset(input int i);
        m_act[i]  = 1'b0;
        m_t[i]    = 0;
        m_tbl[i]  = 4'h0;
        m_mis[i]  = 4'h0;
        m_pass[i] = 1'b0;
        m_done[i] = 1'b0;
    endtask

    task automatic model_step(input int i);
        m_done[i] = 1'b0;
        if (m_act[i]) begin
            m_t[i] = m_t[i] + 1;
            if (m_t[i] % sval[i] == 0 && m_t[i] <= 4 * sval[i])
                m_tbl[i][m_t[i] / sval[i] - 1] = y_s[i];
            if (m_t[i] == 4 * sval[i] + 1) begin
                m_act[i]  = 1'b0;
                m_done[i] = 1'b1;
                m_mis[i]  = m_tbl[i] ^ EXP_NOR;
                m_pass[i] = (m_tbl[i] == EXP_NOR);
            end
        end else if (st_s[i]) begin
            m_act[i]  = 1'b1;
            m_t[i]    = 0;
            m_tbl[i]  = 4'h0;
            m_mis[i]  = 4'h0;
            m_pass[i] = 1'b0;
        end
    endtask

    function automatic logic [1:0] exp_ab(input int i);
        if (m_act[i] && m_t[i] < 4 * sval[i]) return 2'(m_t[i] / sval[i]);
        return 2'b00;
    endfunction

    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset(0);
                model_reset(1);
            end else begin
                model_step(0);
                model_step(1);
            end
        end
    end

    // Inputs and A/B are stable from just after the falling edge until the next rising edge
    initial begin
        forever begin
            @(negedge clk);
            #1;
            y_s  = y;
            st_s = start;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("m_ab",    i, {a_w[i], b_w[i]}, exp_ab(i));
                chk("m_busy",  i, busy_w[i], m_act[i]);
                chk("m_done",  i, done_w[i], m_done[i]);
                chk("m_table", i, tbl_w[i], m_tbl[i]);
                chk("m_mis",   i, mis_w[i], m_mis[i]);
                chk("m_pass",  i, pass_w[i], m_pass[i]);
            end
        end
    end

    task automatic chk_all_zero(input string nm, input int i);
        chk({nm, "_ab"},    i, {a_w[i], b_w[i]}, 0);
        chk({nm, "_busy"},  i, busy_w[i], 0);
        chk({nm, "_done"},  i, done_w[i], 0);
        chk({nm, "_table"}, i, tbl_w[i], 0);
        chk({nm, "_mis"},   i, mis_w[i], 0);
        chk({nm, "_pass"},  i, pass_w[i], 0);
    endtask

    task automatic pulse_start(input int i);
        @(negedge clk);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    // Returns number of edges after the accepting edge until done is seen (0 = timeout)
    task automatic wait_done(input int i, input bit extra, output int n);
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start[i] = extra && (k == 2 || k == 5);
            if (done_w[i]) begin
                n = k;
                break;
            end
        end
        start[i] = 1'b0;
    endtask

    task automatic run_lit(input int i, input int g, input int exp_n,
                           input logic [3:0] et, input bit extra);
        int n;
        int pulses;
        gsel[i] = g;
        pulse_start(i);
        wait_done(i, extra, n);
        chk("lit_latency", i, n, exp_n);
        chk("lit_table",   i, tbl_w[i], et);
        chk("lit_mis",     i, mis_w[i], et ^ EXP_NOR);
        chk("lit_pass",    i, pass_w[i], et == EXP_NOR);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_w[i]) pulses++;
        end
        chk("lit_extra_done", i, pulses, 0);
        chk("lit_hold",       i, tbl_w[i], et);
    endtask

    initial begin
        int n;
        int pulses;
        rst   = 1'b1;
        start = 2'b00;
        gsel  = '{0, 0};
        rnd_y = 2'b00;
        repeat (2) @(negedge clk);
        chk_all_zero("rst", 0);
        chk_all_zero("rst", 1);
        #2 rst = 1'b0;

        run_lit(0, 0, 9, 4'b0001, 1'b0);   // NOR cell
        run_lit(0, 1, 9, 4'b1110, 1'b0);   // OR cell graded against NOR
        run_lit(0, 5, 9, 4'b0000, 1'b0);   // Y tied low
        run_lit(0, 0, 9, 4'b0001, 1'b1);   // extra starts at E0+3, E0+6

        // Asynchronous reset mid-run aborts with no done
        gsel[0] = 0;
        pulse_start(0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("abort", 0);
        @(negedge clk);
        #2 rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_w[0]) pulses++;
        end
        chk("abort_no_done", 0, pulses, 0);
        run_lit(0, 0, 9, 4'b0001, 1'b0);

        // Settle of 1 with restart in the done cycle
        gsel[1] = 0;
        pulse_start(1);
        wait_done(1, 1'b0, n);
        chk("s1_latency", 1, n, 5);
        chk("s1_pass",    1, pass_w[1], 1);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        chk("s1_restart_busy",  1, busy_w[1], 1);
        chk("s1_restart_done",  1, done_w[1], 0);
        chk("s1_restart_table", 1, tbl_w[1], 0);
        chk("s1_restart_pass",  1, pass_w[1], 0);
        wait_done(1, 1'b0, n);
        chk("s1_latency2", 1, n, 5);
        chk("s1_table2",   1, tbl_w[1], 4'b0001);
        chk("s1_pass2",    1, pass_w[1], 1);

        // Randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                start[i] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 19) == 0) gsel[i] = int'($urandom_range(0, 6));
            end
            rnd_y = 2'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                #4 rst = 1'b0;
            end
        end
        @(negedge clk);
        start = 2'b00;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
